// File: rtl/mh_ones_complement_accumulator_if.sv
// Word-in / hash-out handshake bundle for the MMH-MH ones'-complement accumulator.
interface mh_ones_complement_accumulator_if #(
    parameter int unsigned NUM_SEG = 16,
    parameter int unsigned SEG_W   = 192
) ();

    logic [NUM_SEG*SEG_W-1:0] in_data;
    logic                     in_last;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEG_W-1:0]         hash_out;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data,
        output in_last,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  hash_out,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_last,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output hash_out,
        output out_valid
    );

endinterface

// File: rtl/mh_ones_complement_accumulator.sv
// Sums the shifted segments of each word modulo 2^SEG_W-1 (end-around carry), one segment
// per cycle, across words until a last word, then emits the canonical hash.
module mh_ones_complement_accumulator #(
    parameter int unsigned NUM_SEG = 16,
    parameter int unsigned SEG_W   = 192,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    mh_ones_complement_accumulator_if.slave        bus,
    output logic                                   busy
);

    localparam int unsigned WORD_W = NUM_SEG * SEG_W;

    typedef enum logic [1:0] {StIdle, StAccum, StNorm, StOut} state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   seg_cnt_q, seg_cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               last_q, last_d;
    logic [SEG_W-1:0]   hash_q, hash_d;
    logic               out_valid_q, out_valid_d;

    logic [SEG_W-1:0]   seg;
    logic [SEG_W:0]     sum;
    logic [SEG_W-1:0]   norm;

    assign seg  = word_q[seg_cnt_q * SEG_W +: SEG_W];
    assign sum  = {1'b0, acc_q} + {1'b0, seg};
    // Negative zero (all ones) folds to the canonical zero.
    assign norm = (acc_q == {SEG_W{1'b1}}) ? '0 : acc_q;

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.hash_out  = hash_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        seg_cnt_d   = seg_cnt_q;
        word_d      = word_q;
        last_d      = last_q;
        hash_d      = hash_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && bus.in_ready) begin
                    word_d    = bus.in_data;
                    last_d    = bus.in_last;
                    seg_cnt_d = '0;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                // Adding the carry back into a value <= 2^SEG_W-2 cannot overflow again.
                acc_d     = sum[SEG_W-1:0] + {{(SEG_W-1){1'b0}}, sum[SEG_W]};
                seg_cnt_d = seg_cnt_q + 1'b1;
                if (seg_cnt_q == CNT_W'(NUM_SEG - 1)) begin
                    state_d = last_q ? StNorm : StIdle;
                end
            end
            StNorm: begin
                acc_d       = norm;
                hash_d      = norm;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            seg_cnt_q   <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            hash_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            seg_cnt_q   <= seg_cnt_d;
            word_q      <= word_d;
            last_q      <= last_d;
            hash_q      <= hash_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mh_ones_complement_accumulator.sv
// Self-checking bench: table of single-word frames plus hand-written multi-word,
// backpressure and reset sequences; expected hashes flow through a scoreboard queue.
module tb_mh_ones_complement_accumulator;

    localparam int unsigned NUM_SEG = 16;
    localparam int unsigned SEG_W   = 192;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORD_W  = NUM_SEG * SEG_W;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct {
        word_t data;
        seg_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    mh_ones_complement_accumulator_if #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) bus ();

    mh_ones_complement_accumulator #(
        .NUM_SEG (NUM_SEG),
        .SEG_W   (SEG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    seg_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check_seg(input string name, input seg_t act, input seg_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain wide sum, then fold the overflow back until it fits.
    function automatic seg_t model(input word_t d);
        logic [SEG_W+7:0] s;
        logic [SEG_W+7:0] m;
        s = '0;
        m = {8'h00, {SEG_W{1'b1}}};
        for (int n = 0; n < NUM_SEG; n++) s = s + {8'h00, d[n*SEG_W +: SEG_W]};
        while ((s >> SEG_W) != 0) s = (s & m) + (s >> SEG_W);
        if (s == m) s = '0;
        return s[SEG_W-1:0];
    endfunction

    function automatic word_t put(input word_t d, input int n, input seg_t v);
        d[n*SEG_W +: SEG_W] = v;
        return d;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input word_t d, input logic last, input seg_t exp);
        int k;
        k = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            check_bit("accept_timeout", bus.in_ready, 1'b1);
            bus.in_valid = 1'b0;
            return;
        end
        if (last) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_output(input string name, input int lat, input int hold);
        int   k;
        seg_t exp;
        seg_t h;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) begin
            check_bit({name, "_timeout"}, bus.out_valid, 1'b1);
            return;
        end
        check_int({name, "_latency"}, k, lat);
        if (sb.size() == 0) begin
            check_int({name, "_unexpected"}, 1, 0);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        check_seg({name, "_hash"}, bus.hash_out, exp);
        h = bus.hash_out;
        for (int i = 0; i < hold; i++) begin
            bus.in_data  = '1;
            bus.in_last  = 1'b1;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check_seg({name, "_hold_hash"}, bus.hash_out, h);
            check_bit({name, "_hold_valid"}, bus.out_valid, 1'b1);
            check_bit({name, "_hold_in_ready"}, bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_bit({name, "_release_valid"}, bus.out_valid, 1'b0);
        check_bit({name, "_release_busy"}, busy, 1'b0);
        check_bit({name, "_release_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[$];
        vec_t  v;
        word_t z;
        seg_t  half;
        seg_t  ones;

        z    = '0;
        half = '0;
        half[SEG_W-1] = 1'b1;
        ones = '1;

        v.data = put(z, 0, 1);                          v.exp = 1; vecs.push_back(v);
        v.data = put(put(z, 0, half), 1, half);         v.exp = 1; vecs.push_back(v);
        v.data = '1;                                    v.exp = 0; vecs.push_back(v);
        v.data = z;                                     v.exp = 0; vecs.push_back(v);
        v.data = put(put(z, 15, 3), 0, 5);              v.exp = 8; vecs.push_back(v);
        v.data = put(put(z, 0, half), 5, half - 1);     v.exp = 0; vecs.push_back(v);
        v.data = put(put(z, 2, ones), 9, 4);            v.exp = 4; vecs.push_back(v);
        for (int r = 0; r < 3; r++) begin
            v.data = rand_word();
            v.exp  = model(v.data);
            vecs.push_back(v);
        end

        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_seg("reset_hash", bus.hash_out, '0);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("post_reset_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // out_ready with nothing pending must do nothing
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("idle_out_ready_valid", bus.out_valid, 1'b0);
        check_bit("idle_out_ready_busy", busy, 1'b0);
        bus.out_ready = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            send_word(vecs[i].data, 1'b1, vecs[i].exp);
            expect_output($sformatf("vec%0d", i), 17, 0);
        end

        // Two-word frame: no output after the first word, IDLE again after E16.
        send_word(put(z, 3, 5), 1'b0, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_bit("two_word_no_output", bus.out_valid, 1'b0);
            if (k == 15) check_bit("two_word_busy_ready", bus.in_ready, 1'b0);
            if (k == 16) check_bit("two_word_idle_ready", bus.in_ready, 1'b1);
        end
        send_word(put(z, 7, 7), 1'b1, 12);
        expect_output("two_word", 17, 0);

        send_word(put(z, 1, 33), 1'b1, 33);
        expect_output("backpressure", 17, 5);
        send_word(put(z, 4, 6), 1'b1, 6);
        expect_output("after_bp", 17, 0);

        // Reset mid-accumulation, after segment 7 has been added.
        send_word(put(z, 0, 100), 1'b1, 100);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_seg("mid_rst_hash", bus.hash_out, '0);
        check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
        check_bit("mid_rst_in_ready", bus.in_ready, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(put(z, 0, 9), 1'b1, 9);
        expect_output("after_rst", 17, 0);

        check_int("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mh_ones_complement_accumulator.md
Name: mh_ones_complement_accumulator

Overview:
- Downstream stage of the circular left shift unit in the MMH-MH privacy-amplification datapath.
- A 192-bit circular left shift equals multiplication by a power of two modulo M = 2^192-1. This block sums the 16 shifted 192-bit segments modulo M using end-around-carry addition, one segment per cycle.
- Accumulation continues across several input words until a word flagged last arrives. The block then emits the canonical 192-bit hash over a valid/ready handshake.

Parameters:
- NUM_SEG, 16, segments per input word.
- SEG_W, 192, segment width in bits; modulus is M = 2^SEG_W-1.
- CNT_W, 4, segment counter width; must satisfy 2^CNT_W >= NUM_SEG.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_SEG*SEG_W  shifted segments; segment n occupies bits [n*SEG_W +: SEG_W].
- in_last  input  1  qualifies in_data as the final word of a key block.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word.
- hash_out  output  SEG_W  canonical sum modulo M.
- out_valid  output  1  hash_out valid.
- out_ready  input  1  consumer accepts hash_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state = IDLE, acc = 0, seg_cnt = 0, word buffer = 0, last_q = 0.
  - hash_out = 0, out_valid = 0, in_ready = 0 while rst is high, busy = 0.
- States: IDLE, ACCUM, NORM, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_data into a word buffer, in_last into last_q, set seg_cnt = 0, go to ACCUM.
  - in_data is not sampled at any other time.
- ACCUM:
  - in_ready = 0.
  - Each cycle: s = {1'b0, acc} + {1'b0, buf[seg_cnt]} (SEG_W+1 bits); acc <= s[SEG_W-1:0] + s[SEG_W]; seg_cnt increments.
  - The end-around add cannot carry again.
  - After the add with seg_cnt == NUM_SEG-1: go to NORM if last_q, else IDLE with acc retained.
- NORM (one cycle):
  - If acc == all ones, acc <= 0; otherwise acc is unchanged.
  - Go to OUT; hash_out <= normalized acc; out_valid <= 1.
- OUT:
  - hash_out and out_valid stay stable while out_ready = 0.
  - On out_ready: out_valid <= 0, acc <= 0, go to IDLE.
  - in_ready = 0 throughout OUT.
- Latency:
  - A last word accepted at edge E0 adds segments on E1..E16 and normalizes on E17.
  - out_valid is high after E17, i.e. 17 cycles after acceptance with NUM_SEG = 16.
  - A non-last word returns to IDLE after E16; the next word can be accepted at E17.
- Throughput: one word per NUM_SEG+1 cycles.
- Boundary conditions:
  - Segment order does not affect the result.
  - An all-zero frame yields 0.
  - A frame summing to M yields 0, never all ones.
  - in_valid asserted outside IDLE is ignored; the upstream holds the word until in_ready.
  - out_ready asserted while out_valid = 0 has no effect.
  - rst asserted in any state returns immediately to reset values; a partial frame is discarded.

Test Plan:
- Single last word, segment 0 = 1, all others 0 -> out_valid 17 cycles after acceptance, hash_out = 1.
- Last word, segments 0 and 1 = 2^191, others 0 -> end-around carry, hash_out = 1.
- Last word, all 16 segments = 2^192-1 -> NORM canonicalizes, hash_out = 0.
- Two-word frame: word A (in_last = 0) segment 3 = 5; word B (in_last = 1) segment 7 = 7 -> no output after A, in_ready high again at E17; after B, hash_out = 12.
- Backpressure: out_ready held low 5 cycles after out_valid with in_valid held high -> hash_out stable, in_ready = 0, no new word accepted; the following frame starts from acc = 0.
- rst pulsed mid-ACCUM at seg_cnt = 8 -> all outputs zero, busy = 0; a following single-segment frame with value 9 yields hash_out = 9.
